regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_clear_fsm.sv | 76 +++++++
 rtl/regfile_multiport.sv | 96 +++++++++
 tb/tb_regfile_multiport.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the multiport register file:
//   - default geometry constants (WIDTH, DEPTH, NREAD)
//   - clear controller state enumeration
//   - address-width helper used to size index ports and the clear counter
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREAD = 2;

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // Index width for a file of 'depth' entries (depth is a power of two >= 2).
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm
//   Sequences a whole-file clear, one entry per cycle, and flags writes that
//   arrive while the clear is running.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     clr_req     : start a clear (ignored while one is already running)
//     we          : write enable from the host, used only to detect drops
//     busy        : clear in progress; clr_idx is the entry zeroed this cycle
//     clr_idx     : entry being cleared in the current busy cycle
//     wr_drop     : one-cycle pulse, the write of the previous cycle was dropped
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    input  logic          we,
    output logic          busy,
    output logic [AW-1:0] clr_idx,
    output logic          wr_drop
);

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_drop_q, wr_drop_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = 1'b0;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                // Any write offered while clearing is lost; report it next cycle.
                wr_drop_d = we;
                // Counter wraps to 0 naturally when leaving on the last entry,
                // and clr_req is deliberately not looked at here.
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = CLR_IDLE;
                end
            end
            default: begin
                state_d = CLR_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLR_IDLE;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    assign busy    = (state_q == CLR_CLEAR);
    assign clr_idx = cnt_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport
//   One write port, NREAD combinational read ports, optional hardwired zero
//   register, optional same-cycle write-to-read forwarding, and a sequenced
//   whole-file clear.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset (zeroes the file)
//     we/waddr/wdata : write port
//     raddr       : NREAD packed read indices, port i at [i*AW +: AW]
//     rdata       : NREAD packed read words,  port i at [i*WIDTH +: WIDTH]
//     clr_req     : request a clear of every entry
//     busy        : clear in progress, host writes are dropped
//     wr_drop     : one-cycle pulse after a dropped write
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NREAD    = DEF_NREAD,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = addr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   wr_drop
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    clr_idx;
    logic             wr_to_zero;
    logic             wr_acc;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk     (clk),
        .reset   (reset),
        .clr_req (clr_req),
        .we      (we),
        .busy    (busy),
        .clr_idx (clr_idx),
        .wr_drop (wr_drop)
    );

    // Writes to a hardwired zero register vanish silently (no drop pulse).
    assign wr_to_zero = (ZERO_REG != 0) && (waddr == '0);
    assign wr_acc     = we && !busy && !wr_to_zero;

    always_comb begin
        mem_d = mem_q;
        if (busy) begin
            mem_d[clr_idx] = '0;
        end else if (wr_acc) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    idx;
        logic [WIDTH-1:0] rd_word;

        assign idx = raddr[i*AW +: AW];

        // wr_acc already excludes busy, so forwarding is off during a clear.
        always_comb begin
            if ((ZERO_REG != 0) && (idx == '0)) begin
                rd_word = '0;
            end else if ((BYPASS != 0) && wr_acc && (idx == waddr)) begin
                rd_word = wdata;
            end else begin
                rd_word = mem_q[idx];
            end
        end

        assign rdata[i*WIDTH +: WIDTH] = rd_word;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport
//   Drives two instances from the same stimulus: dut_a with the default
//   configuration (zero register, forwarding) and dut_b with both disabled.
//   Expected values come from hand-written vectors and from a reference model
//   that tracks the file contents and the remaining clear length.
module tb_regfile_multiport;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] ra [2];
    logic [2*AW-1:0] raddr;
    logic          clr_req;
    logic [2*W-1:0] rdata_a, rdata_b;
    logic          busy_a, busy_b, wr_drop_a, wr_drop_b;

    assign raddr = {ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_a), .clr_req(clr_req), .busy(busy_a), .wr_drop(wr_drop_a)
    );

    regfile_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .clr_req(clr_req), .busy(busy_b), .wr_drop(wr_drop_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] m_a [D];
    logic [W-1:0] m_b [D];
    int           clr_left = 0;
    logic         m_drop   = 1'b0;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [W-1:0]  exp_a0;
        logic [W-1:0]  exp_a1;
        logic [W-1:0]  exp_b1;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [W-1:0]  ea;
        logic [W-1:0]  eb;
        logic [AW-1:0] idx;
        for (int p = 0; p < 2; p++) begin
            idx = ra[p];
            if (idx == 0)
                ea = '0;
            else if (clr_left == 0 && we && waddr != 0 && waddr == idx)
                ea = wdata;
            else
                ea = m_a[idx];
            eb = m_b[idx];
            chk("rd_a", rdata_a[p*W +: W], ea);
            chk("rd_b", rdata_b[p*W +: W], eb);
        end
        chk("busy_a", {31'b0, busy_a}, {31'b0, clr_left > 0});
        chk("busy_b", {31'b0, busy_b}, {31'b0, clr_left > 0});
        chk("drop_a", {31'b0, wr_drop_a}, {31'b0, m_drop});
        chk("drop_b", {31'b0, wr_drop_b}, {31'b0, m_drop});
    endtask

    task automatic model_edge();
        int k;
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                m_a[i] = '0;
                m_b[i] = '0;
            end
            clr_left = 0;
            m_drop   = 1'b0;
        end else begin
            m_drop = we && (clr_left > 0);
            if (clr_left > 0) begin
                k = D - clr_left;
                m_a[k] = '0;
                m_b[k] = '0;
                clr_left--;
            end else begin
                if (we) begin
                    if (waddr != 0) m_a[waddr] = wdata;
                    m_b[waddr] = wdata;
                end
                if (clr_req) clr_left = D;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        if (!reset) check_all();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle();
        settle();
        edge_step();
    endtask

    vec_t vecs [7];
    int   busy_cnt;
    logic stop;

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ra[0] = '0; ra[1] = '0; clr_req = 1'b0;
        for (int i = 0; i < D; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0};
        vecs[5] = '{1'b1, 5'd7, 32'h11111111, 5'd7, 5'd7, 32'h11111111, 32'h11111111, 32'hA5A5A5A5};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF};

        edge_step();
        edge_step();
        reset = 1'b0;

        // Directed vectors: write/read, zero register, forwarding
        for (int v = 0; v < 7; v++) begin
            we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            ra[0] = vecs[v].ra0; ra[1] = vecs[v].ra1;
            settle();
            chk("vec_a0", rdata_a[W-1:0], vecs[v].exp_a0);
            chk("vec_a1", rdata_a[2*W-1:W], vecs[v].exp_a1);
            chk("vec_b1", rdata_b[2*W-1:W], vecs[v].exp_b1);
            chk("vec_drop", {31'b0, wr_drop_a}, 32'h0);
            edge_step();
        end
        we = 1'b0;

        // Fill every entry, then clear with a dropped write and a second request
        for (int i = 0; i < D; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = 32'hFFFFFFFF; ra[0] = AW'(i); ra[1] = 5'd31;
            cycle();
        end
        we = 1'b0; ra[0] = 5'd10; ra[1] = 5'd31; clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        busy_cnt = 0;
        stop = 1'b0;
        for (int j = 0; j < 100; j++) begin
            we = (j == 5); waddr = 5'd3; wdata = 32'h0BADF00D;
            clr_req = (j == 8);
            settle();
            if (busy_a !== 1'b1) begin
                stop = 1'b1;
            end else begin
                busy_cnt++;
                // Entry 10 is zeroed by the edge that closes busy cycle index 10.
                if (j == 10) chk("e10_before", rdata_a[W-1:0], 32'hFFFFFFFF);
                if (j == 11) chk("e10_after", rdata_a[W-1:0], 32'h0);
                if (j == 31) chk("e31_last", rdata_a[2*W-1:W], 32'hFFFFFFFF);
                if (j == 6)  chk("drop_pulse", {31'b0, wr_drop_a}, 32'h1);
                if (j == 7)  chk("drop_once", {31'b0, wr_drop_a}, 32'h0);
            end
            edge_step();
            if (stop) break;
        end
        we = 1'b0; clr_req = 1'b0;
        chk("busy_len", 32'(busy_cnt), 32'd32);
        ra[0] = 5'd3; ra[1] = 5'd31;
        settle();
        chk("e3_after", rdata_a[W-1:0], 32'h0);
        chk("e31_after", rdata_a[2*W-1:W], 32'h0);
        edge_step();

        // Reset in the middle of a clear, with we and clr_req in the reset cycle
        for (int i = 1; i < 9; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = $urandom; ra[0] = AW'(i); ra[1] = 5'd20;
            cycle();
        end
        we = 1'b0; clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int j = 0; j < 11; j++) cycle();
        reset = 1'b1; we = 1'b1; waddr = 5'd20; wdata = 32'hCAFEF00D; clr_req = 1'b1;
        edge_step();
        reset = 1'b0; we = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < D / 2; i++) begin
            ra[0] = AW'(2 * i); ra[1] = AW'(2 * i + 1);
            settle();
            if (i == 0) chk("rst_busy", {31'b0, busy_a}, 32'h0);
            chk("rst_rd_a0", rdata_a[W-1:0], 32'h0);
            chk("rst_rd_a1", rdata_a[2*W-1:W], 32'h0);
            chk("rst_rd_b1", rdata_b[2*W-1:W], 32'h0);
            edge_step();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            reset   = ($urandom_range(0, 199) == 0);
            we      = $urandom_range(0, 1);
            waddr   = AW'($urandom_range(0, D - 1));
            wdata   = $urandom;
            ra[0]   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, D - 1));
            ra[1]   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, D - 1));
            clr_req = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
